uart_transmitter: RTL and testbench

- Serial transmit end of the on-chip UART; drives the FPGA_SERIAL_TX line of the CPU top level.
- Accepts one byte per ready/valid handshake from the CPU's memory-mapped I/O write path.
- Emits the byte as an asynchronous 8N1 frame: start bit, 8 data bits LSB first, stop bit.
- Timing is derived from a clock-cycle baud counter.

---
 rtl/uart_transmitter.sv | 162 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter with a ready/valid byte input and a
//               flop-driven TX line. Define UART_TX_PARITY_EN to insert an
//               even-parity bit between the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int c_BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [c_BAUD_W-1:0]  w_baud_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic                 r_serial;
    logic                 w_serial_nxt;
    logic                 w_baud_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_nxt;
`endif

    assign w_baud_done   = (r_baud == c_BAUD_LAST);
    assign data_in_ready = (r_state == S_IDLE);
    assign busy          = ~data_in_ready;
    assign serial_out    = r_serial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_serial  <= w_serial_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // The line level for the next bit period is computed here so that it
    // leaves a flop on the same edge that the state advances.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_serial_nxt = r_serial;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        if (r_state != S_IDLE) begin
            w_baud_nxt = w_baud_done ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                if (data_in_valid) begin
                    w_state_nxt  = S_START;
                    w_baud_nxt   = '0;
                    w_bit_nxt    = '0;
                    w_shift_nxt  = data_in;
                    w_serial_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^data_in;
`endif
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt  = S_DATA;
                    w_bit_nxt    = '0;
                    w_serial_nxt = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt  = S_PARITY;
                        w_serial_nxt = r_parity;
`else
                        w_state_nxt  = S_STOP;
                        w_serial_nxt = 1'b1;
`endif
                    end else begin
                        w_serial_nxt = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt  = S_STOP;
                    w_serial_nxt = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt  = S_IDLE;
                    w_serial_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_baud_nxt   = '0;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Scoreboard bench for uart_transmitter; a monitor decodes
//               frames on serial_out against queued expected frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int CPB        = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS      = 11;
    localparam int NFRAMES    = 8;
`else
    localparam int NBITS      = 10;
    localparam int NFRAMES    = 6;
`endif
    localparam int FRAME      = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] bits;
        int          gap;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;
    int aborts = 0;
    int frames = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected line levels, index 0 = start bit; parity is supplied by hand.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
        return {1'b1, par, d, 1'b0};
`else
        return {1'b1, par & 1'b0 | 1'b1, d, 1'b0};
`endif
    endfunction

    // Monitor: detect start bit, pop expectation, sample each bit mid-period.
    initial begin : monitor
        int last_start;
        last_start = -1000;
        forever begin
            @(negedge clk);
            if (rst && serial_out == 1'b0) begin
                int   st;
                exp_t e;
                bit   ab;
                st = cyc;
                ab = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", st);
                    repeat (FRAME - 1) @(negedge clk);
                    continue;
                end
                e = sb.pop_front();
                frames++;
                if (e.gap != 0) check("start_gap", st - last_start, e.gap);
                last_start = st;
                for (int k = 0; k < NBITS; k++) begin
                    for (int c = 0; c < ((k == 0) ? CPB / 2 : CPB); c++) begin
                        @(negedge clk);
                        if (!rst) ab = 1'b1;
                    end
                    if (ab) break;
                    check($sformatf("bit%0d_of_%02h", k, e.d), serial_out, e.bits[k]);
                end
                if (ab) aborts++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!data_in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!data_in_ready) begin
            checks++;
            $display("FAIL %s: got data_in_ready=0, expected 1 within 400 cycles", name);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input int gap, output int acc);
        exp_t e;
        e.bits = frame_of(d, par);
        e.gap  = gap;
        e.d    = d;
        sb.push_back(e);
        wait_ready("send_ready");
        data_in       = d;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        acc           = cyc;
        data_in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!data_in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin : stimulus
        int   acc;
        int   n;
        int   ones;
        exp_t e;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial_out", serial_out, 1);
        check("rst_ready", data_in_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        ones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (serial_out === 1'b1 && data_in_ready === 1'b1) ones++;
        end
        check("idle_line_ones", ones, 20);

        // Single byte 0xA5, busy for exactly one frame
        send(8'hA5, 1'b0, 0, acc);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", data_in_ready, 0);
        count_busy(n);
        check("busy_cycles_A5", n, FRAME);
        check("busy_low_after_A5", busy, 0);
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back 0x00 then 0xFF with valid held
        e.bits = frame_of(8'h00, 1'b0); e.gap = 0;         e.d = 8'h00; sb.push_back(e);
        e.bits = frame_of(8'hFF, 1'b0); e.gap = FRAME + 1; e.d = 8'hFF; sb.push_back(e);
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hFF;
        wait_ready("b2b_ready");
        check("gap_idle_level", serial_out, 1);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        repeat (FRAME + 20) @(posedge clk);
        #1;

        // Input ignored while busy
        send(8'h81, 1'b0, 0, acc);
        repeat (30) @(posedge clk);
        #1;
        data_in       = 8'h3C;
        data_in_valid = 1'b1;
        check("ready_midframe", data_in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        repeat (FRAME + 40) @(posedge clk);
        #1;

        // Reset mid-frame, then a clean frame
        send(8'h55, 1'b0, 0, acc);
        repeat (35) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_serial_out", serial_out, 1);
        check("midrst_ready", data_in_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(8'h0F, 1'b0, 0, acc);
        repeat (FRAME + 20) @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 has odd weight, 0x03 even weight
        send(8'h07, 1'b1, 0, acc);
        count_busy(n);
        check("busy_cycles_07", n, FRAME);
        repeat (20) @(posedge clk);
        #1;
        send(8'h03, 1'b0, 0, acc);
        repeat (FRAME + 20) @(posedge clk);
        #1;
`endif

        check("queue_drained", sb.size(), 0);
        check("aborted_frames", aborts, 1);
        check("frames_started", frames, NFRAMES);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
